// File: rtl/mem_wb_stage.sv
// MIPS32 memory-access / writeback stage: ALU results pass straight to writeback,
// loads and stores run one req/ack bus transaction, then write back.
module mem_wb_stage #(
  parameter int DW     = 32,
  parameter int AW_REG = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_wreg,
  input  logic [AW_REG-1:0] ex_wd,
  input  logic [DW-1:0]     ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [DW-1:0]     ex_maddr,
  input  logic [DW-1:0]     ex_sdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DW-1:0]     bus_addr,
  output logic [3:0]        bus_sel,
  output logic [DW-1:0]     bus_wdata,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              bus_ack,
  output logic              stall_req,
  output logic              wb_we,
  output logic [AW_REG-1:0] wb_waddr,
  output logic [DW-1:0]     wb_wdata,
  output logic              exc_adel,
  output logic              exc_ades
);

  typedef enum logic [3:0] {
    MOP_NONE = 4'd0, MOP_LB = 4'd1, MOP_LBU = 4'd2, MOP_LH = 4'd3, MOP_LHU = 4'd4,
    MOP_LW   = 4'd5, MOP_SB = 4'd6, MOP_SH  = 4'd7, MOP_SW = 4'd8
  } mop_e;

  typedef enum logic {S_IDLE, S_BUS} state_e;

  state_e              state;
  mop_e                mop_q;
  logic                wreg_q;
  logic [AW_REG-1:0]   wd_q;
  logic [1:0]          off_q;

  logic                is_load, is_store, is_half, is_word, misaligned, accept_mem;
  logic [3:0]          sel_fmt;
  logic [DW-1:0]       wdata_fmt;
  logic [DW-1:0]       rd_shift;
  logic [DW-1:0]       load_data;
  logic [15:0]         rd_half;

  // Decode of the op presented by EX; codes above SW fall through as NONE.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    sel_fmt   = 4'b0000;
    wdata_fmt = '0;
    case (ex_memop)
      MOP_LB, MOP_LBU: begin is_load  = 1'b1; sel_fmt = 4'b1000 >> ex_maddr[1:0]; end
      MOP_LH, MOP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MOP_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      MOP_SB: begin
        is_store  = 1'b1;
        sel_fmt   = 4'b1000 >> ex_maddr[1:0];
        wdata_fmt = {4{ex_sdata[7:0]}};
      end
      MOP_SH: begin is_store = 1'b1; is_half = 1'b1; wdata_fmt = {2{ex_sdata[15:0]}}; end
      MOP_SW: begin is_store = 1'b1; is_word = 1'b1; wdata_fmt = ex_sdata; end
      default: ;
    endcase
    if (is_half) sel_fmt = ex_maddr[1] ? 4'b0011 : 4'b1100;
    if (is_word) sel_fmt = 4'b1111;
  end

  assign misaligned = (is_half && ex_maddr[0]) || (is_word && (ex_maddr[1:0] != 2'b00));
  assign accept_mem = (state == S_IDLE) && ex_valid && (is_load || is_store) && !misaligned;
  assign stall_req  = (state == S_IDLE) ? accept_mem : !bus_ack;

  // Big-endian lanes: byte offset 0 lives in bits 31:24, so shift right by (3-off) bytes.
  assign rd_shift = bus_rdata >> {~off_q, 3'b000};
  assign rd_half  = off_q[1] ? bus_rdata[15:0] : bus_rdata[31:16];

  always_comb begin
    load_data = '0;
    case (mop_q)
      MOP_LB:  load_data = {{(DW-8){rd_shift[7]}}, rd_shift[7:0]};
      MOP_LBU: load_data = {{(DW-8){1'b0}}, rd_shift[7:0]};
      MOP_LH:  load_data = {{(DW-16){rd_half[15]}}, rd_half};
      MOP_LHU: load_data = {{(DW-16){1'b0}}, rd_half};
      MOP_LW:  load_data = bus_rdata;
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mop_q     <= MOP_NONE;
      wreg_q    <= 1'b0;
      wd_q      <= '0;
      off_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= 4'b0000;
      bus_wdata <= '0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      exc_adel  <= 1'b0;
      exc_ades  <= 1'b0;
    end else begin
      wb_we    <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            if (!(is_load || is_store)) begin
              wb_we    <= ex_wreg;
              wb_waddr <= ex_wd;
              wb_wdata <= ex_wdata;
            end else if (misaligned) begin
              exc_adel <= is_load;
              exc_ades <= is_store;
            end else begin
              state     <= S_BUS;
              mop_q     <= mop_e'(ex_memop);
              wreg_q    <= ex_wreg;
              wd_q      <= ex_wd;
              off_q     <= ex_maddr[1:0];
              bus_req   <= 1'b1;
              bus_we    <= is_store;
              bus_addr  <= {ex_maddr[DW-1:2], 2'b00};
              bus_sel   <= sel_fmt;
              bus_wdata <= wdata_fmt;
            end
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            state     <= S_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_sel   <= 4'b0000;
            bus_wdata <= '0;
            if (mop_q inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW}) begin
              wb_we    <= wreg_q;
              wb_waddr <= wd_q;
              wb_wdata <= load_data;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of ops driven through a bench-side bus slave,
// with writebacks/exceptions checked against a scoreboard queue.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_maddr, ex_sdata;
  logic [3:0]  ex_memop;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        stall_req, wb_we, exc_adel, exc_ades;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DW(32), .AW_REG(5)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_wd(ex_wd), .ex_wdata(ex_wdata),
    .ex_memop(ex_memop), .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_req(stall_req), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .exc_adel(exc_adel), .exc_ades(exc_ades)
  );

  typedef struct {
    logic [3:0]  mop;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        stall;   // aligned memory op: goes to the bus
    logic        st;      // store
    logic [1:0]  exc;     // 0 none, 1 AdEL, 2 AdES
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] res;     // expected wb_wdata when a GPR write is expected
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adel;
    logic        ades;
  } wb_t;

  wb_t  sb_q[$];
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] mop, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input logic stall,
                              input logic st, input logic [1:0] exc, input logic [3:0] sel,
                              input logic [31:0] bwdata, input logic [31:0] res);
    vec_t v;
    v.mop = mop; v.addr = addr; v.sdata = sdata; v.wreg = wreg; v.wd = wd; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits; v.stall = stall; v.st = st; v.exc = exc; v.sel = sel;
    v.bwdata = bwdata; v.res = res;
    return v;
  endfunction

  // Scoreboard consumer: every writeback or exception pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (wb_we || exc_adel || exc_ades)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wb", {wb_we, exc_adel, exc_ades}, 3'b000);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_flags", {wb_we, exc_adel, exc_ades}, {e.we, e.adel, e.ades});
        if (e.we) begin
          check("wb_waddr", wb_waddr, e.waddr);
          check("wb_wdata", wb_wdata, e.wdata);
        end
      end
    end
  end

  task automatic drive_junk();
    ex_valid = 1'b1; ex_memop = 4'd0; ex_wreg = 1'b1; ex_wd = 5'd31; ex_wdata = 32'hFFFF_FFFF;
  endtask

  task automatic do_op(input vec_t v);
    wb_t e;
    ex_valid = 1'b1; ex_memop = v.mop; ex_maddr = v.addr; ex_sdata = v.sdata;
    ex_wreg = v.wreg; ex_wd = v.wd; ex_wdata = v.wdata;
    #1;
    check("accept_stall", stall_req, v.stall);
    if (v.exc != 2'd0) begin
      e.we = 1'b0; e.waddr = '0; e.wdata = '0; e.adel = (v.exc == 2'd1); e.ades = (v.exc == 2'd2);
      sb_q.push_back(e);
    end else if (v.wreg && !v.st) begin
      e.we = 1'b1; e.waddr = v.wd; e.wdata = v.res; e.adel = 1'b0; e.ades = 1'b0;
      sb_q.push_back(e);
    end
    step();
    ex_valid = 1'b0;
    if (v.stall) begin
      check("bus_req", bus_req, 1'b1);
      check("bus_we", bus_we, v.st);
      check("bus_addr", bus_addr, {v.addr[31:2], 2'b00});
      check("bus_sel", bus_sel, v.sel);
      if (v.st) check("bus_wdata", bus_wdata, v.bwdata);
      for (int i = 0; i < v.waits; i++) begin
        drive_junk();
        #1;
        check("wait_stall", stall_req, 1'b1);
        step();
        check("hold_req", bus_req, 1'b1);
        check("hold_sel", bus_sel, v.sel);
      end
      drive_junk();
      bus_ack = 1'b1; bus_rdata = v.rdata;
      #1;
      check("ack_stall", stall_req, 1'b0);
      step();
      bus_ack = 1'b0; bus_rdata = $urandom; ex_valid = 1'b0;
      check("req_drop", bus_req, 1'b0);
    end else begin
      check("no_bus_req", bus_req, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0;
    ex_memop = '0; ex_maddr = '0; ex_sdata = '0; bus_ack = 1'b0; bus_rdata = '0;

    //           mop    addr          sdata         wr wd     wdata         rdata        w  stl st exc sel      bwdata        res
    vecs[0]  = mk(4'd0, 32'h0,        32'h0,        1, 5'd5,  32'h1234_5678, 32'h0,       0, 0, 0, 0, 4'b0000, 32'h0,        32'h1234_5678);
    vecs[1]  = mk(4'd0, 32'h0,        32'h0,        0, 5'd7,  32'h0BAD_0BAD, 32'h0,       0, 0, 0, 0, 4'b0000, 32'h0,        32'h0);
    vecs[2]  = mk(4'd0, 32'h0,        32'h0,        1, 5'd0,  32'hDEAD_BEEF, 32'h0,       0, 0, 0, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF);
    vecs[3]  = mk(4'd1, 32'h1001,     32'h0,        1, 5'd8,  32'h0,         32'h1180_2233, 2, 1, 0, 0, 4'b0100, 32'h0,      32'hFFFF_FF80);
    vecs[4]  = mk(4'd2, 32'h1003,     32'h0,        1, 5'd9,  32'h0,         32'h1122_33F4, 0, 1, 0, 0, 4'b0001, 32'h0,      32'h0000_00F4);
    vecs[5]  = mk(4'd3, 32'h2000,     32'h0,        1, 5'd10, 32'h0,         32'h8001_1234, 1, 1, 0, 0, 4'b1100, 32'h0,      32'hFFFF_8001);
    vecs[6]  = mk(4'd4, 32'h2002,     32'h0,        1, 5'd11, 32'h0,         32'hAAAA_F00D, 0, 1, 0, 0, 4'b0011, 32'h0,      32'h0000_F00D);
    vecs[7]  = mk(4'd5, 32'h2004,     32'h0,        1, 5'd12, 32'h0,         32'hCAFE_BABE, 0, 1, 0, 0, 4'b1111, 32'h0,      32'hCAFE_BABE);
    vecs[8]  = mk(4'd7, 32'h10,       32'h0000_BEEF, 1, 5'd13, 32'h0,        32'h0,       0, 1, 1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    vecs[9]  = mk(4'd8, 32'h14,       32'h0123_4567, 0, 5'd14, 32'h0,        32'h0,       0, 1, 1, 0, 4'b1111, 32'h0123_4567, 32'h0);
    vecs[10] = mk(4'd6, 32'h22,       32'h0000_00A5, 0, 5'd15, 32'h0,        32'h0,       1, 1, 1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    vecs[11] = mk(4'd5, 32'h3,        32'h0,        1, 5'd16, 32'h0,         32'h0,       0, 0, 0, 1, 4'b0000, 32'h0,        32'h0);
    vecs[12] = mk(4'd8, 32'h3,        32'h1111_1111, 0, 5'd17, 32'h0,        32'h0,       0, 0, 1, 2, 4'b0000, 32'h0,        32'h0);
    vecs[13] = mk(4'd3, 32'h4001,     32'h0,        1, 5'd18, 32'h0,         32'h0,       0, 0, 0, 1, 4'b0000, 32'h0,        32'h0);
    vecs[14] = mk(4'hF, 32'h5,        32'h0,        1, 5'd19, 32'h0000_55AA, 32'h0,       0, 0, 0, 0, 4'b0000, 32'h0,        32'h0000_55AA);
    vecs[15] = mk(4'd1, 32'h0,        32'h0,        0, 5'd3,  32'h0,         32'h7F00_0000, 0, 1, 0, 0, 4'b1000, 32'h0,      32'h0);

    step();
    step();
    check("rst_bus", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, '0);
    check("rst_wb", {wb_we, wb_waddr, wb_wdata}, '0);
    check("rst_exc_stall", {exc_adel, exc_ades, stall_req}, 3'b000);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) do_op(vecs[i]);

    // bus_ack seen while idle must be ignored
    bus_ack = 1'b1; bus_rdata = 32'h5A5A_5A5A;
    #1;
    check("idle_ack_stall", stall_req, 1'b0);
    step();
    bus_ack = 1'b0;
    check("idle_ack_req", bus_req, 1'b0);

    // reset while a load is outstanding abandons the transaction
    ex_valid = 1'b1; ex_memop = 4'd5; ex_maddr = 32'h40; ex_wreg = 1'b1; ex_wd = 5'd20;
    step();
    ex_valid = 1'b0;
    check("pre_rst_req", bus_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("post_rst_req", bus_req, 1'b0);
    check("post_rst_stall", stall_req, 1'b0);
    check("post_rst_wb", {wb_we, exc_adel, exc_ades}, 3'b000);
    do_op(vecs[0]);

    step();
    step();
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
